// File: rtl/btn_debounce_pkg.sv
// Shared state encoding and width helpers for the multi-channel button debouncer.
package btn_debounce_pkg;

    typedef logic [1:0] btn_state_t;

    localparam btn_state_t ST_RELEASED = 2'd0;
    localparam btn_state_t ST_PRESSED  = 2'd1;
    localparam btn_state_t ST_HELD     = 2'd2;

    // Counter width for a terminal count of n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, debounce, press/release/long strobes.
// Auto-repeat in HELD is built only when BTN_AUTOREPEAT_EN is defined.
module btn_debounce_ch
    import btn_debounce_pkg::*;
#(
    parameter int MIN_PULSE_WIDTH  = 100,
    parameter int LONGPRESS_CYCLES = 1000000,
    parameter int REPEAT_CYCLES    = 250000,
    parameter bit ACTIVE_LOW       = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_btn,
    output logic o_rise,
    output logic o_fall,
    output logic o_long,
    output logic o_repeat
);

    localparam int DW = cnt_w(MIN_PULSE_WIDTH);
    localparam int HW = cnt_w(max_i(LONGPRESS_CYCLES, REPEAT_CYCLES));
    localparam logic [DW-1:0] DB_MAX = DW'(MIN_PULSE_WIDTH - 1);
    localparam logic [HW-1:0] LP_MAX = HW'(LONGPRESS_CYCLES - 1);

    logic            sync1, sync2, s_prev, s_btn;
    logic [DW-1:0]   db_cnt;
    logic [HW-1:0]   hcnt;
    btn_state_t      state;
    logic            load, rise_ev, fall_ev;

    assign s_btn = ACTIVE_LOW ? ~sync2 : sync2;

    // s_btn must also match s_prev so a change landing on a saturated counter is not taken.
    assign load    = (s_btn == s_prev) && (db_cnt == DB_MAX) && (s_btn != o_btn);
    assign rise_ev = load &  s_btn;
    assign fall_ev = load & ~s_btn;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            s_prev <= 1'b0;
            db_cnt <= '0;
            o_btn  <= 1'b0;
            o_rise <= 1'b0;
            o_fall <= 1'b0;
        end else begin
            sync1  <= i_btn;
            sync2  <= sync1;
            s_prev <= s_btn;
            if (s_btn != s_prev)
                db_cnt <= '0;
            else if (db_cnt != DB_MAX)
                db_cnt <= db_cnt + 1'b1;
            if (load)
                o_btn <= s_btn;
            o_rise <= rise_ev;
            o_fall <= fall_ev;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [HW-1:0] RP_MAX = HW'(REPEAT_CYCLES - 1);
    logic rep_r;
    assign o_repeat = rep_r;
`else
    assign o_repeat = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= ST_RELEASED;
            hcnt   <= '0;
            o_long <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            rep_r  <= 1'b0;
`endif
        end else begin
            o_long <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            rep_r  <= 1'b0;
`endif
            case (state)
                // Release is checked first so it beats a coincident hold terminal count.
                ST_PRESSED: begin
                    if (fall_ev) begin
                        state <= ST_RELEASED;
                        hcnt  <= '0;
                    end else if (hcnt == LP_MAX) begin
                        o_long <= 1'b1;
                        state  <= ST_HELD;
                        hcnt   <= '0;
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (fall_ev) begin
                        state <= ST_RELEASED;
                        hcnt  <= '0;
                    end
`ifdef BTN_AUTOREPEAT_EN
                    else if (hcnt == RP_MAX) begin
                        rep_r <= 1'b1;
                        hcnt  <= '0;
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
`endif
                end
                default: begin
                    hcnt  <= '0;
                    state <= rise_ev ? ST_PRESSED : ST_RELEASED;
                end
            endcase
        end
    end

endmodule

// File: rtl/btn_debounce_multi.sv
// NUM_BTNS independent debounced button channels with press/release/long strobes.
// Define BTN_AUTOREPEAT_EN to enable o_repeat pulses while a button is held.
module btn_debounce_multi
    import btn_debounce_pkg::*;
#(
    parameter int NUM_BTNS         = 4,
    parameter int MIN_PULSE_WIDTH  = 100,
    parameter int LONGPRESS_CYCLES = 1000000,
    parameter int REPEAT_CYCLES    = 250000,
    parameter bit ACTIVE_LOW       = 1'b0
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NUM_BTNS-1:0] i_btn,
    output logic [NUM_BTNS-1:0] o_btn,
    output logic [NUM_BTNS-1:0] o_rise,
    output logic [NUM_BTNS-1:0] o_fall,
    output logic [NUM_BTNS-1:0] o_long,
    output logic [NUM_BTNS-1:0] o_repeat
);

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_ch
        btn_debounce_ch #(
            .MIN_PULSE_WIDTH (MIN_PULSE_WIDTH),
            .LONGPRESS_CYCLES(LONGPRESS_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_ch (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_btn   (i_btn[g]),
            .o_btn   (o_btn[g]),
            .o_rise  (o_rise[g]),
            .o_fall  (o_fall[g]),
            .o_long  (o_long[g]),
            .o_repeat(o_repeat[g])
        );
    end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Directed bench for btn_debounce_multi: 2 channels, MPW=4, long=20, repeat=8.
module tb_btn_debounce_multi;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [1:0] i_btn;
    logic [1:0] o_btn, o_rise, o_fall, o_long, o_repeat;

    int checks = 0;
    int errors = 0;

    btn_debounce_multi #(
        .NUM_BTNS        (2),
        .MIN_PULSE_WIDTH (4),
        .LONGPRESS_CYCLES(20),
        .REPEAT_CYCLES   (8),
        .ACTIVE_LOW      (1'b0)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_btn   (i_btn),
        .o_btn   (o_btn),
        .o_rise  (o_rise),
        .o_fall  (o_fall),
        .o_long  (o_long),
        .o_repeat(o_repeat)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        logic [9:0] all_o;
        i_rst = 1'b1;
        i_btn = 2'b00;
        settle(2);
        all_o = {o_btn, o_rise, o_fall, o_long, o_repeat};
        checks++;
        if (all_o !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", all_o, 10'd0);
        end
        i_rst = 1'b0;
        settle(2);
    endtask

    task automatic test_clean_press();
        int btn_t = -1, nrise = 0, rise_t = -1, fall_t = -1, nfall = 0;
        bit ch1_bad = 1'b0;
        i_btn[0] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (o_btn[0] && btn_t < 0) btn_t = k;
            if (o_rise[0]) begin nrise++; rise_t = k; end
            if (o_btn[1] | o_rise[1] | o_fall[1] | o_long[1]) ch1_bad = 1'b1;
        end
        checks++;
        if (btn_t < 5 || btn_t > 7) begin
            errors++;
            $display("FAIL press_latency: got %0d expected 5..7", btn_t);
        end
        checks++;
        if (nrise != 1 || rise_t != btn_t) begin
            errors++;
            $display("FAIL press_rise: got count %0d at %0d expected 1 at %0d", nrise, rise_t, btn_t);
        end
        checks++;
        if (ch1_bad !== 1'b0) begin
            errors++;
            $display("FAIL press_ch1_quiet: got %b expected 0", ch1_bad);
        end
        i_btn[0] = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (o_fall[0]) begin nfall++; fall_t = k; end
        end
        checks++;
        if (nfall != 1 || fall_t < 5 || fall_t > 7 || o_btn[0] !== 1'b0) begin
            errors++;
            $display("FAIL release_fall: got count %0d at %0d btn %b expected 1 at 5..7 btn 0",
                     nfall, fall_t, o_btn[0]);
        end
    endtask

    task automatic test_glitch();
        bit seen_btn = 1'b0, seen_rise = 1'b0, seen_fall = 1'b0;
        i_btn[0] = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (k == 3) i_btn[0] = 1'b0;
            seen_btn  |= o_btn[0];
            seen_rise |= o_rise[0];
            seen_fall |= o_fall[0];
        end
        checks++;
        if ({seen_btn, seen_rise, seen_fall} !== 3'b000) begin
            errors++;
            $display("FAIL glitch_reject: got btn/rise/fall %b%b%b expected 000",
                     seen_btn, seen_rise, seen_fall);
        end
    endtask

    task automatic test_long_press();
        int rise_t = -1, long_t = -1, nlong = 0, nrep = 0, nfall = 0;
        int rep_t0 = -1, rep_t1 = -1;
        bit ch0_bad = 1'b0;
        i_btn[1] = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (o_rise[1] && rise_t < 0) rise_t = k;
            if (o_long[1]) begin nlong++; long_t = k; end
            if (o_repeat[1]) begin
                if (nrep == 0) rep_t0 = k;
                if (nrep == 1) rep_t1 = k;
                nrep++;
            end
            if (o_fall[1]) nfall++;
            if (o_btn[0] | o_rise[0] | o_long[0] | o_repeat[0]) ch0_bad = 1'b1;
            if (k == 40) i_btn[1] = 1'b0;
        end
        checks++;
        if (nlong != 1 || long_t - rise_t != 20) begin
            errors++;
            $display("FAIL long_timing: got count %0d offset %0d expected 1 offset 20",
                     nlong, long_t - rise_t);
        end
`ifdef BTN_AUTOREPEAT_EN
        checks++;
        if (nrep != 2 || rep_t0 != long_t + 8 || rep_t1 != long_t + 16) begin
            errors++;
            $display("FAIL repeat_timing: got count %0d at %0d,%0d expected 2 at %0d,%0d",
                     nrep, rep_t0, rep_t1, long_t + 8, long_t + 16);
        end
`else
        checks++;
        if (nrep != 0) begin
            errors++;
            $display("FAIL repeat_off: got count %0d expected 0", nrep);
        end
`endif
        checks++;
        if (nfall != 1 || o_btn[1] !== 1'b0) begin
            errors++;
            $display("FAIL long_release: got falls %0d btn %b expected 1 btn 0", nfall, o_btn[1]);
        end
        checks++;
        if (ch0_bad !== 1'b0) begin
            errors++;
            $display("FAIL long_ch0_quiet: got %b expected 0", ch0_bad);
        end
    endtask

    // Release lands the fall ~15 cycles after rise, then exactly on the hold terminal count.
    task automatic test_release_before_long();
        for (int r = 0; r < 2; r++) begin
            int rel = (r == 0) ? 8 : 13;
            int nrise = 0, nfall = 0, fall_k = -1, nlong = 0;
            i_btn[0] = 1'b1;
            for (int k = 1; k <= 12 && nrise == 0; k++) begin
                tick();
                if (o_rise[0]) nrise++;
            end
            checks++;
            if (nrise != 1) begin
                errors++;
                $display("FAIL rbl_rise_timeout: got %0d rises expected 1", nrise);
            end
            for (int k = 1; k <= 35; k++) begin
                tick();
                if (o_fall[0]) begin nfall++; fall_k = k; end
                if (o_long[0]) nlong++;
                if (k == rel) i_btn[0] = 1'b0;
            end
            checks++;
            if (nfall != 1 || fall_k < rel + 5 || fall_k > rel + 7) begin
                errors++;
                $display("FAIL rbl_fall_%0d: got count %0d at %0d expected 1 at %0d..%0d",
                         rel, nfall, fall_k, rel + 5, rel + 7);
            end
            checks++;
            if (nlong != 0) begin
                errors++;
                $display("FAIL rbl_no_long_%0d: got %0d expected 0", rel, nlong);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        int nrise = 0, rise_k = -1;
        logic [9:0] all_o;
        i_btn[0] = 1'b1;
        for (int k = 1; k <= 12 && nrise == 0; k++) begin
            tick();
            if (o_rise[0]) nrise++;
        end
        settle(3);
        checks++;
        if (o_btn[0] !== 1'b1) begin
            errors++;
            $display("FAIL rst_hold_pre: got btn %b expected 1", o_btn[0]);
        end
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        all_o = {o_btn, o_rise, o_fall, o_long, o_repeat};
        checks++;
        if (all_o !== 10'd0) begin
            errors++;
            $display("FAIL rst_hold_clear: got %b expected %b", all_o, 10'd0);
        end
        nrise = 0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (o_rise[0]) begin nrise++; rise_k = k; end
        end
        checks++;
        if (nrise != 1 || rise_k < 5 || rise_k > 8) begin
            errors++;
            $display("FAIL rst_requalify: got count %0d at %0d expected 1 at 5..8", nrise, rise_k);
        end
        i_btn[0] = 1'b0;
        settle(12);
    endtask

    task automatic test_bounce();
        int nrise = 0, rise_k = -1, nfall = 0;
        for (int k = 0; k <= 24; k++) begin
            if (k < 10) i_btn[0] = ((k / 2) % 2 == 0);
            else        i_btn[0] = 1'b1;
            tick();
            if (o_rise[0]) begin nrise++; rise_k = k + 1; end
            if (o_fall[0]) nfall++;
        end
        // Final toggle to 1 is driven just before the edge numbered 9.
        checks++;
        if (nrise != 1 || rise_k - 8 < 5 || rise_k - 8 > 7) begin
            errors++;
            $display("FAIL bounce_rise: got count %0d offset %0d expected 1 offset 5..7",
                     nrise, rise_k - 8);
        end
        checks++;
        if (nfall != 0) begin
            errors++;
            $display("FAIL bounce_no_fall: got %0d expected 0", nfall);
        end
        i_btn[0] = 1'b0;
        settle(12);
    endtask

    task automatic test_simultaneous();
        int both = 0, single = 0;
        i_btn = 2'b11;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (o_rise == 2'b11) both++;
            else if (o_rise != 2'b00) single++;
        end
        checks++;
        if (both != 1 || single != 0) begin
            errors++;
            $display("FAIL simul_rise: got both %0d single %0d expected 1 and 0", both, single);
        end
        i_btn = 2'b00;
        settle(12);
    endtask

    initial begin
        i_rst = 1'b1;
        i_btn = 2'b00;
        test_reset();
        test_clean_press();
        test_glitch();
        test_long_press();
        test_release_before_long();
        test_reset_mid_hold();
        test_bounce();
        test_simultaneous();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
